mtm_alu_deserializer: RTL

//  Serial-to-parallel front end of the ALU: receives the input serial line `sin`.

---
 rtl/mtm_alu_pkg.sv | 29 ++
 rtl/mtm_alu_deser_crc4.sv | 12 +
 rtl/mtm_alu_deserializer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared ALU package: FSM states, packet type codes and CRC4 helper.
// Used by the deserializer, serializer and core.
package mtm_alu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TYPE,
      PAYLOAD,
      STOP
   } state_t;

   localparam logic PKT_TYPE_DATA = 1'b0;
   localparam logic PKT_TYPE_CMD  = 1'b1;

   // x^4 + x + 1, implicit x^4 term
   localparam logic [3:0] CRC4_POLY = 4'h3;

   function automatic logic [3:0] crc4_68(input logic [67:0] d);
      logic [3:0] c;
      logic       fb;
      c = '0;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ d[i];
         c  = {c[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'h0);
      end
      return c;
   endfunction

endpackage

// File: rtl/mtm_alu_deser_crc4.sv
// Combinational CRC4 over the 68-bit word {B, A, 1'b1, OP}.
// Only instantiated when MTM_DESER_CRC_CHECK_EN is defined.
module mtm_alu_deser_crc4
   import mtm_alu_pkg::*;
(
   input  logic [67:0] data,
   output logic [3:0]  crc
);

   assign crc = crc4_68(data);

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial-to-parallel ALU front end: 8 DATA packets + CMD -> A, B, OP, CRC.
// Define MTM_DESER_CRC_CHECK_EN to enable the CRC4 check and err_crc.
module mtm_alu_deserializer
   import mtm_alu_pkg::*;
#(
   parameter int DATA_PKTS = 8,
   parameter int PKT_W     = 8
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sin,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [2:0]  OP,
   output logic [3:0]  CRC,
   output logic        dout_valid,
   output logic        err_data,
   output logic        err_crc,
   output logic        err_frame
);

   localparam int BW = $clog2(PKT_W);
   localparam int CW = $clog2(DATA_PKTS + 1);
   localparam int SW = DATA_PKTS * PKT_W;
   localparam logic [CW-1:0] FULL = CW'(DATA_PKTS);
   localparam logic [BW-1:0] LAST = BW'(PKT_W - 1);

   state_t          state;
   state_t          state_n;
   logic [BW-1:0]   bit_cnt;
   logic [CW-1:0]   pkt_cnt;
   logic            pkt_type;
   logic            overrun;
   logic [PKT_W-1:0] sr;
   logic [SW-1:0]   stage;

   logic stop_ok;
   logic data_done;
   logic cmd_done;
   logic cnt_ok;
   logic crc_ok;
   logic valid_d;
   logic err_data_d;
   logic err_frame_d;
   logic last_bit;

   assign last_bit = (bit_cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (!sin) state_n = TYPE;
         TYPE:    state_n = PAYLOAD;
         PAYLOAD: if (last_bit) state_n = STOP;
         STOP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      stop_ok     = (state == STOP) && sin;
      data_done   = stop_ok && (pkt_type == PKT_TYPE_DATA);
      cmd_done    = stop_ok && (pkt_type == PKT_TYPE_CMD);
      cnt_ok      = (pkt_cnt == FULL) && !overrun;
      valid_d     = cmd_done && cnt_ok && crc_ok;
      err_data_d  = cmd_done && !cnt_ok;
      err_frame_d = (state == STOP) && !sin;
   end

`ifdef MTM_DESER_CRC_CHECK_EN
   logic [3:0] crc_calc;

   mtm_alu_deser_crc4 u_crc (
      .data ({stage, 1'b1, sr[6:4]}),
      .crc  (crc_calc)
   );

   assign crc_ok = (crc_calc == sr[3:0]);

   always_ff @(posedge clk) begin
      if (!rst_n) err_crc <= 1'b0;
      else        err_crc <= cmd_done && cnt_ok && !crc_ok;
   end
`else
   assign crc_ok  = 1'b1;
   assign err_crc = 1'b0;
`endif

   // Bytes arrive B MSB first, so shifting in yields {B, A}
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt    <= '0;
         pkt_cnt    <= '0;
         pkt_type   <= 1'b0;
         overrun    <= 1'b0;
         sr         <= '0;
         stage      <= '0;
         A          <= '0;
         B          <= '0;
         OP         <= '0;
         CRC        <= '0;
         dout_valid <= 1'b0;
         err_data   <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         dout_valid <= valid_d;
         err_data   <= err_data_d;
         err_frame  <= err_frame_d;
         if (state == TYPE) begin
            pkt_type <= sin;
            bit_cnt  <= '0;
         end
         if (state == PAYLOAD) begin
            sr      <= {sr[PKT_W-2:0], sin};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (data_done) begin
            if (pkt_cnt == FULL) begin
               overrun <= 1'b1;
            end else begin
               stage   <= {stage[SW-PKT_W-1:0], sr};
               pkt_cnt <= pkt_cnt + 1'b1;
            end
         end
         if (cmd_done || err_frame_d) begin
            pkt_cnt <= '0;
            overrun <= 1'b0;
         end
         if (valid_d) begin
            B   <= stage[63:32];
            A   <= stage[31:0];
            OP  <= sr[6:4];
            CRC <= sr[3:0];
         end
      end
   end

endmodule
